mod_unit_seq: RTL and testbench
===============================

Name: mod_unit_seq

Overview:
- Multi-cycle modulo unit that computes A mod B for the MIPS ALU.
- Its registered result feeds the MOD input of the ALU's 32-bit 8:1 result-select mux.
- Uses restoring shift-subtract, one quotient bit per cycle, so latency is fixed and independent of the data values.
- The ALU control starts it with `start` and samples `result` when `done` is high.

Parameters:
- WIDTH, 32, operand and result width. It must stay 32 when the block drives the ALU result mux.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation. Sampled only while in IDLE.
- a  input  WIDTH  dividend. Captured on the accepted start.
- b  input  WIDTH  divisor. Captured on the accepted start.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse: result is valid.
- div_zero  output  1  the captured b was 0. Valid with done and held until the next accepted start.
- result  output  WIDTH  remainder. Registered and held stable until the next accepted start or reset.

Behaviour:
- Reset values: busy=0, done=0, div_zero=0, result=0, state=IDLE, iteration counter=0.
- Reset during any state, including mid-CALC, aborts the operation. Outputs take their reset values on the next edge and the block is in IDLE.
- State machine: IDLE -> CALC -> DONE -> IDLE. It moves directly IDLE -> DONE when b=0.
- IDLE, start=1 at edge N, b!=0:
  - capture a into the quotient shift register and b into the divisor register;
  - clear the partial remainder and the counter;
  - state goes to CALC; busy=1 from N+1.
- IDLE, start=1, b=0:
  - state goes to DONE at N+1 with result=a and div_zero=1;
  - done=1 during cycle N+1.
- CALC, one step per cycle:
  - rem' = {rem[WIDTH-2:0], q[WIDTH-1]}; q shifts left by 1.
  - If rem' >= divisor: rem = rem' - divisor, and shift 1 into q[0]. Otherwise rem = rem', and shift 0 into q[0].
  - Compare and subtract are done in WIDTH+1 bits so there is no overflow when rem' has its MSB set.
  - Counter increments from 0 to WIDTH-1; after step WIDTH-1 the state goes to DONE.
- DONE:
  - result <= final remainder, loaded on the CALC->DONE edge;
  - done=1 for exactly one cycle, busy=0;
  - next state is IDLE unconditionally.
- Latency: start accepted at edge N gives done high in cycle N+WIDTH+1 (N+33 for WIDTH=32). The divide-by-zero path gives done at N+1.
- Start handling:
  - start asserted in CALC or DONE is ignored, not queued;
  - start held high continuously re-triggers at each return to IDLE.
- result and div_zero do not change during CALC. The previous result stays on the mux input until the new one is written.
- a and b may change freely after the accepted start edge.
- A < B yields result=A after the full latency. There is no early exit.

Optional Feature:
- Macro: MOD_SIGNED_EN.
- Defined:
  - a and b are treated as two's complement;
  - magnitudes are taken at capture (|0x80000000| = 0x80000000, handled as unsigned);
  - the final remainder is negated when a was negative, giving MIPS/C semantics: the sign follows the dividend and b's sign is irrelevant;
  - latency is unchanged because the negation is folded into the CALC->DONE load;
  - the b=0 path still returns result=a.
- Undefined: fully unsigned operation, and no abs/negate logic is synthesised.

Test Plan:
- Basic: reset 2 cycles, then start with a=17, b=5 at edge N -> busy=1 from N+1 through N+32; done=1 only in N+33 with result=2, div_zero=0; result still 2 at N+40.
- Wide values: a=0xFFFFFFFF, b=0x10 -> result=0x0000000F. Then a=0xFFFFFFEF, b=5 -> result=4 when unsigned (macro undefined), or result=0xFFFFFFFE (-2) with MOD_SIGNED_EN.
- Divide by zero and small dividend:
  - a=123, b=0 at N -> done=1 and div_zero=1 in N+1, result=123, busy never asserts.
  - Next, a=3, b=7 -> result=3 at N'+33, div_zero returns to 0.
- Start ignored while busy: start a=100, b=7; pulse start with a=9, b=2 at N+10 -> done only at N+33 with result=2; no second done follows.
- Reset mid-operation: start a=1000, b=3, assert reset at N+10 -> at N+11 busy=0, done=0, result=0. Restart a=1000, b=3 -> result=1 after 33 cycles.
- Signed edge cases (MOD_SIGNED_EN):
  - a=0x80000000, b=0xFFFFFFFF -> result=0;
  - a=-7, b=-3 -> 0xFFFFFFFF;
  - a=7, b=-3 -> 1.

Source files
------------

// File: rtl/mod_unit_seq_if.sv
// -----------------------------------------------------------------------------
// mod_unit_seq_if
//   Request/response bundle between the ALU control and the sequential modulo
//   unit (mod_unit_seq).
//
//   Signals:
//     start     control -> unit  request a new A mod B (sampled in IDLE only)
//     a         control -> unit  dividend, captured on the accepted start
//     b         control -> unit  divisor, captured on the accepted start
//     busy      unit -> control  high while the shift-subtract loop runs
//     done      unit -> control  one-cycle pulse, result is valid
//     div_zero  unit -> control  captured divisor was zero (held until next start)
//     result    unit -> control  registered remainder (feeds the ALU MOD mux leg)
//
//   Modports:
//     master  ALU control side
//     slave   modulo unit side
// -----------------------------------------------------------------------------
interface mod_unit_seq_if #(
  parameter int unsigned WIDTH = 32
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] result;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  div_zero,
    input  result
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output div_zero,
    output result
  );

endinterface

// File: rtl/mod_unit_seq.sv
// -----------------------------------------------------------------------------
// mod_unit_seq
//   Multi-cycle A mod B for the MIPS ALU. Restoring shift-subtract, one
//   quotient bit per cycle, so latency is fixed at WIDTH cycles of CALC plus
//   one DONE cycle regardless of operand values. A zero divisor skips CALC and
//   returns the dividend with div_zero set.
//
//   Ports:
//     clk    system clock, all state changes on the rising edge
//     reset  synchronous, active-high; aborts any operation in flight
//     bus    mod_unit_seq_if.slave (start, a, b, busy, done, div_zero, result)
//
//   Parameters:
//     WIDTH  operand/result width; must remain 32 when driving the ALU mux
//
//   Build option:
//     MOD_SIGNED_EN  when defined, a and b are two's complement; magnitudes are
//                    divided and the remainder takes the sign of the dividend
//                    (C/MIPS semantics). When undefined the unit is purely
//                    unsigned and no abs/negate logic exists.
// -----------------------------------------------------------------------------
module mod_unit_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  mod_unit_seq_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  // Datapath registers
  logic [WIDTH-1:0] q_r;       // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] rem_r;     // partial remainder
  logic [WIDTH-1:0] dvsr_r;    // captured divisor (magnitude in signed builds)
  logic [WIDTH-1:0] result_r;  // value presented to the ALU mux
  logic             dz_r;
  logic [CW-1:0]    cnt_r;
`ifdef MOD_SIGNED_EN
  logic             neg_r;     // dividend was negative: negate final remainder
`endif

  // Combinational helpers
  logic             accept;
  logic             b_is_zero;
  logic             last_step;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH-1:0] rem_final;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    accept    = (state == IDLE) && bus.start;
    b_is_zero = (bus.b == '0);
    last_step = (state == CALC) && (cnt_r == LAST_STEP);
  end

  // ---------------------------------------------------------------------------
  // Operand conditioning at capture time. In signed builds the most negative
  // value maps onto itself, which is its correct magnitude when read unsigned.
  // ---------------------------------------------------------------------------
  always_comb begin
`ifdef MOD_SIGNED_EN
    a_mag = bus.a[WIDTH-1] ? ('0 - bus.a) : bus.a;
    b_mag = bus.b[WIDTH-1] ? ('0 - bus.b) : bus.b;
`else
    a_mag = bus.a;
    b_mag = bus.b;
`endif
  end

  // ---------------------------------------------------------------------------
  // One restoring step. The shifted remainder is kept WIDTH+1 bits wide so a
  // divisor above 2^(WIDTH-1) never loses the carried-out bit; the borrow of
  // the WIDTH+1 bit subtract is the "does not fit" indication.
  // ---------------------------------------------------------------------------
  always_comb begin
    rem_sh = {rem_r, q_r[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvsr_r};
    ge     = ~diff[WIDTH];
    rem_nx = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    q_nx   = {q_r[WIDTH-2:0], ge};
  end

  // Sign fix-up is folded into the CALC->DONE load so latency is unchanged.
  always_comb begin
`ifdef MOD_SIGNED_EN
    rem_final = neg_r ? ('0 - rem_nx) : rem_nx;
`else
    rem_final = rem_nx;
`endif
  end

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = b_is_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_step) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r      <= '0;
      rem_r    <= '0;
      dvsr_r   <= '0;
      result_r <= '0;
      dz_r     <= 1'b0;
      cnt_r    <= '0;
`ifdef MOD_SIGNED_EN
      neg_r    <= 1'b0;
`endif
    end else if (accept) begin
      if (b_is_zero) begin
        // Dividend passes through unchanged (raw, not its magnitude).
        result_r <= bus.a;
        dz_r     <= 1'b1;
      end else begin
        q_r    <= a_mag;
        dvsr_r <= b_mag;
        rem_r  <= '0;
        cnt_r  <= '0;
        dz_r   <= 1'b0;
`ifdef MOD_SIGNED_EN
        neg_r  <= bus.a[WIDTH-1];
`endif
      end
    end else if (state == CALC) begin
      rem_r <= rem_nx;
      q_r   <= q_nx;
      cnt_r <= cnt_r + CW'(1);
      // result_r holds the previous answer until the final step lands.
      if (last_step) begin
        result_r <= rem_final;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from registers, so they are glitch-free to the mux.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.busy     = (state == CALC);
    bus.done     = (state == DONE);
    bus.div_zero = dz_r;
    bus.result   = result_r;
  end

endmodule

// File: tb/tb_mod_unit_seq.sv
// -----------------------------------------------------------------------------
// tb_mod_unit_seq
//   Scoreboard bench for mod_unit_seq. The stimulus process pushes the expected
//   remainder, div_zero flag and latency for every accepted start; a monitor
//   pops on each done pulse. Expected values come from plain % arithmetic on
//   the operands (sign rules applied when MOD_SIGNED_EN is defined).
// -----------------------------------------------------------------------------
module tb_mod_unit_seq;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mod_unit_seq_if #(.WIDTH(W)) bus ();

  mod_unit_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        dz;
    int unsigned acc;
    int unsigned lat;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] held  = '0;
  int unsigned busy_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_mod(input logic [31:0] x, input logic [31:0] y);
`ifdef MOD_SIGNED_EN
    longint sx;
    longint sy;
    longint r;
    bit     neg;
    if (y == 32'd0) return x;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    neg = (sx < 0);
    if (sx < 0) sx = -sx;
    if (sy < 0) sy = -sy;
    r = sx % sy;
    if (neg) r = -r;
    return r[31:0];
`else
    if (y == 32'd0) return x;
    return x % y;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_run = 0;
      end else begin
        if (bus.busy) begin
          busy_run++;
          check("result_stable_in_calc", bus.result, held);
          check("div_zero_low_in_calc", 32'(bus.div_zero), 32'd0);
        end
        if (bus.done) begin
          if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_done: got done=1 expected no done (cycle %0d)", cyc);
          end else begin
            e = sbq.pop_front();
            check("result", bus.result, e.res);
            check("div_zero", 32'(bus.div_zero), 32'(e.dz));
            check("latency", 32'(cyc - e.acc), 32'(e.lat));
            check("busy_cycles", 32'(busy_run), 32'(e.lat));
            check("busy_with_done", 32'(bus.busy), 32'd0);
            held = e.res;
          end
          busy_run = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic wait_idle();
    int unsigned n = 0;
    @(negedge clk);
    while ((bus.busy || bus.done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy || bus.done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got busy=%0b done=%0b expected idle", bus.busy, bus.done);
    end
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  // Drives one request from IDLE; track=0 issues without expecting a done,
  // keep=1 leaves start asserted so the unit re-triggers on its own.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input bit track, input bit keep);
    exp_t e;
    wait_idle();
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (track) begin
      e.res = ref_mod(x, y);
      e.dz  = (y == 32'd0);
      e.acc = cyc;
      e.lat = (y == 32'd0) ? 0 : W;
      sbq.push_back(e);
    end
    if (!keep) bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
  endtask

  function automatic logic [31:0] rand_b();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'($urandom_range(1, 15));
      2:       return $urandom;
      default: return $urandom | 32'h8000_0000;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stim
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_div_zero", 32'(bus.div_zero), 32'd0);
    check("reset_result", bus.result, 32'd0);
    reset = 1'b0;
    held  = '0;

    // Basic, then the result must still hold several cycles after done.
    issue(32'd17, 32'd5, 1, 0);
    wait_drain();
    repeat (7) @(negedge clk);
    check("result_hold_after_done", bus.result, 32'd2);

    // Wide values and a divisor above 2^31.
    issue(32'hFFFF_FFFF, 32'h0000_0010, 1, 0);
    issue(32'hFFFF_FFEF, 32'd5, 1, 0);
    issue(32'hFFFF_FFFF, 32'h8000_0001, 1, 0);

    // Divide by zero followed by a small dividend.
    issue(32'd123, 32'd0, 1, 0);
    issue(32'd3, 32'd7, 1, 0);
    issue(32'd0, 32'd1, 1, 0);

    // Start pulse while busy must be ignored.
    issue(32'd100, 32'd7, 1, 0);
    repeat (9) @(posedge clk);
    #1;
    bus.a     = 32'd9;
    bus.b     = 32'd2;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_drain();
    repeat (40) @(negedge clk);

    // Reset mid-operation aborts without a done.
    issue(32'd1000, 32'd3, 0, 0);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    held = '0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", bus.result, 32'd0);
    check("abort_div_zero", 32'(bus.div_zero), 32'd0);
    reset = 1'b0;
    issue(32'd1000, 32'd3, 1, 0);

    // Sign-sensitive operands (unsigned meaning when the option is off).
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    issue(32'hFFFF_FFF9, 32'hFFFF_FFFD, 1, 0);
    issue(32'd7, 32'hFFFF_FFFD, 1, 0);
    issue(32'h8000_0000, 32'd0, 1, 0);

    // Start held high re-triggers at each return to IDLE.
    for (int i = 0; i < 3; i++) begin
      issue($urandom, rand_b(), 1, (i < 2));
    end

    // Randomised operands.
    for (int i = 0; i < 25; i++) begin
      issue($urandom, rand_b(), 1, 0);
    end

    wait_drain();
    repeat (40) @(negedge clk);
    check("no_extra_done", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no completion expected $finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
